// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver: PS/2 device-to-host frame receiver with parity/stop check, stall watchdog and output FIFO
// Ports: clk_i, rst_ni (async active-low); enable_i gates new frames; ps2_clk_posedge_i/ps2_data_i sample strobe and line;
//   rx_data_o/rx_valid_o/rx_ready_i FIFO head handshake; fifo_level_o occupancy; busy_o frame in flight;
//   err_parity_o/err_frame_o/err_timeout_o/err_overflow_o one-cycle error pulses.
module ps2_frame_receiver #(
  parameter int DATA_BITS      = 8,
  parameter int ODD_PARITY     = 1,
  parameter int CHECK_PARITY   = 1,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FIFO_DEPTH     = 4,
  localparam int LW            = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 ps2_clk_posedge_i,
  input  logic                 ps2_data_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [LW-1:0]        fifo_level_o,
  output logic                 busy_o,
  output logic                 err_parity_o,
  output logic                 err_frame_o,
  output logic                 err_timeout_o,
  output logic                 err_overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d, to_inc;
  logic par_q, par_d, par_ok;
  logic push, pop, wr;
  logic perr_d, ferr_d, terr_d;
  logic perr_q, ferr_q, terr_q, oerr_q;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [LW-1:0] level_q;
  assign to_inc = to_q + 1'b1;
  assign par_ok = (^{shift_q, par_q}) ^ (ODD_PARITY == 0);
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    to_d    = (state_q == IDLE || ps2_clk_posedge_i) ? '0 : to_inc;
    push    = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    terr_d  = 1'b0;
    if (ps2_clk_posedge_i) begin
      case (state_q)
        IDLE: if (enable_i && !ps2_data_i) begin
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          // LSB-first: new bit enters at the top and walks down to bit 0
          shift_d = (shift_q >> 1) | (DATA_BITS'(ps2_data_i) << (DATA_BITS - 1));
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == LAST) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = ps2_data_i;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          ferr_d  = !ps2_data_i;
          perr_d  = ps2_data_i && (CHECK_PARITY != 0) && !par_ok;
          push    = ps2_data_i && !perr_d;
        end
      endcase
    end else if (state_q != IDLE && to_inc == TO_LAST) begin
      state_d = IDLE;
      terr_d  = 1'b1;
    end
  end
  // a push into a full FIFO still lands when the head is popped on the same edge
  assign pop = (level_q != '0) && rx_ready_i;
  assign wr  = push && ((level_q != LW'(FIFO_DEPTH)) || pop);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      terr_q  <= 1'b0;
      oerr_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      terr_q  <= terr_d;
      oerr_q  <= push && !wr;
      if (wr) begin
        mem_q[wp_q] <= shift_q;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      level_q <= level_q + LW'(wr) - LW'(pop);
    end
  end
  assign rx_data_o      = mem_q[rp_q];
  assign rx_valid_o     = level_q != '0;
  assign fifo_level_o   = level_q;
  assign busy_o         = state_q != IDLE;
  assign err_parity_o   = perr_q;
  assign err_frame_o    = ferr_q;
  assign err_timeout_o  = terr_q;
  assign err_overflow_o = oerr_q;
endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Parametrised PS/2 device-to-host frame receiver. Successor to the single-byte PS/2 data input stage.
- Detects the start bit itself, shifts in DATA_BITS LSB-first, checks parity and the stop bit, and aborts stalled frames with a watchdog.
- Buffers good bytes in a FIFO that has a valid/ready output handshake.
- Sits between the PS/2 clock edge detector and the scan-code decoder / Morse encoder front end.

Parameters:
- DATA_BITS, 8: payload bits per frame, range 1..15.
- ODD_PARITY, 1: 1 means the ones in data+parity must be odd; 0 means even.
- CHECK_PARITY, 1: 0 means the parity bit is sampled but ignored.
- TIMEOUT_CYCLES, 20000: clk cycles allowed between ps2_clk_posedge strobes inside a frame, minimum 2.
- FIFO_DEPTH, 4: number of buffered bytes, power of 2, minimum 2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: when low, no new frame starts; an in-flight frame completes.
- ps2_clk_posedge, input, 1: one-cycle strobe from the edge detector; the data sample point.
- ps2_data, input, 1: synchronised PS/2 data line.
- rx_data, output, DATA_BITS: FIFO head byte; valid only while rx_valid=1.
- rx_valid, output, 1: FIFO not empty.
- rx_ready, input, 1: consumer accepts the head when rx_valid and rx_ready are both 1.
- fifo_level, output, $clog2(FIFO_DEPTH+1): current occupancy.
- busy, output, 1: state is not IDLE.
- err_parity, output, 1: one-cycle pulse.
- err_frame, output, 1: one-cycle pulse on a bad stop bit.
- err_timeout, output, 1: one-cycle pulse.
- err_overflow, output, 1: one-cycle pulse.

Behaviour:
- Reset (asynchronous assert, synchronous release to clk):
  - state=IDLE; shift register, bit counter, timeout counter, FIFO pointers and fifo_level all 0.
  - rx_data=0, rx_valid=0, busy=0, all err_* = 0.
- States are IDLE, DATA, PARITY, STOP. All transitions are taken only on a ps2_clk_posedge strobe, except timeout.
- IDLE:
  - strobe && enable && ps2_data==0 → DATA, bit counter=0, timeout counter cleared.
  - strobe with ps2_data==1, or with enable==0, is ignored.
- DATA:
  - Each strobe does shift = {ps2_data, shift[DATA_BITS-1:1]} and increments the counter.
  - On the strobe that captures bit DATA_BITS-1 → PARITY. Exactly DATA_BITS shifts occur per frame.
- PARITY: the strobe latches ps2_data as the parity bit → STOP.
- STOP, on the strobe:
  - ps2_data==0: pulse err_frame; discard the byte.
  - Otherwise, CHECK_PARITY=1 and parity mismatch: pulse err_parity; discard.
  - Otherwise push the shift register to the FIFO.
  - In every case → IDLE on the same edge.
  - Byte is visible at rx_data/rx_valid on the cycle after the stop strobe (latency 1 clk).
- Frame error takes precedence over parity error: at most one error pulse per frame.
- Timeout:
  - Counter increments every clk while busy and clears on each strobe.
  - When it reaches TIMEOUT_CYCLES-1 with no strobe that cycle: pulse err_timeout, → IDLE, discard the partial frame.
  - A strobe in that same cycle wins; no timeout is taken.
- FIFO:
  - Pop occurs when rx_valid && rx_ready. rx_data always shows the head entry.
  - Push is accepted if fifo_level<FIFO_DEPTH, or if a pop happens in the same cycle. Full + push + pop leaves the level unchanged and the byte is stored.
  - Push while full with no pop: byte dropped, pulse err_overflow, FIFO contents untouched.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- enable deasserting mid-frame has no effect until the frame ends.
- rst_n asserting mid-frame aborts it immediately with no error pulse.

Test Plan:
- Reset then idle: rst_n=0 for 3 clk, then 1 → all outputs 0, busy=0, fifo_level=0.
- Good frame, ODD_PARITY=1, rx_ready=0:
  - Stimulus: strobes with bits 0 | 0,0,1,1,1,0,0,0 | 0 | 1 (byte 0x1C).
  - Response: one clk after the stop strobe, rx_valid=1, rx_data=0x1C, fifo_level=1, no err pulses.
  - Then rx_ready=1 for 1 clk → rx_valid=0.
- Error frames:
  - Same as the 0x1C frame with parity bit 1 → err_parity pulses once, fifo_level stays 0.
  - Same frame with stop bit 0 and bad parity → only err_frame pulses.
- Timeout (TIMEOUT_CYCLES=50):
  - Start bit + 3 data strobes, then silence → err_timeout pulses 49 clk after the last strobe, busy=0.
  - A following good 0xA5 frame is received correctly.
- Overflow and wrap (FIFO_DEPTH=4):
  - Send 0x01..0x05 with rx_ready=0 → fifo_level=4, err_overflow on the 5th byte.
  - Then drain → bytes 0x01,0x02,0x03,0x04 in order.
  - Refill 6 bytes while popping → order preserved across pointer wrap.
- Simultaneous push/pop when full: stop strobe coincides with rx_ready=1 → fifo_level stays 4, no err_overflow, new byte lands at the tail.
